// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared playfield geometry, colours and sequencer state encoding
package game_pkg;

   localparam int GRID_W  = 16;
   localparam int GRID_H  = 32;
   localparam int SCALE   = 3;
   localparam int SCALE_W = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [2:0] FG_COLOUR = 3'b000;
   localparam logic [2:0] BG_COLOUR = 3'b001;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_UPDATE = 3'd1;
   localparam logic [2:0] ST_SPAWN  = 3'd2;
   localparam logic [2:0] ST_SHIFT  = 3'd3;
   localparam logic [2:0] ST_ADDR   = 3'd4;
   localparam logic [2:0] ST_PIX    = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   function automatic logic [2:0] cell_colour(input logic occupied);
      return occupied ? FG_COLOUR : BG_COLOUR;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - wrap counter 0..N-1 with enable and terminal-count pulse
module tick_divider #(
   parameter int N = 16
) (
   input  logic clock,
   input  logic resetn,
   input  logic i_en,
   output logic o_tc
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0] r_count;

   // o_tc marks the cycle in which the counter wraps back to zero
   assign o_tc = i_en && (r_count == W'(N - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         r_count <= '0;
      else if (o_tc)
         r_count <= '0;
      else if (i_en)
         r_count <= r_count + 1'b1;
   end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - game tick, spawn/shift sequencing and playfield redraw; FRAME_SEQ_COLLISION_EN adds game_over
module frame_sequencer
   import game_pkg::*;
#(
   parameter int TICK_CYCLES = 833334,
   parameter int SHIFT_DIV   = 16,
   parameter int SPAWN_DIV   = 16
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   output logic [3:0] cell_col,
   output logic [4:0] cell_row,
   input  logic       cell_data,
   input  logic [3:0] player_col,
   output logic       spawn_pulse,
   output logic       shift_pulse,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun,
   output logic       game_over
);

   logic [2:0]         r_state;
   logic               r_pending, r_overrun, r_do_shift, r_do_spawn;
   logic [3:0]         r_col;
   logic [4:0]         r_row;
   logic [SCALE_W-1:0] r_dx, r_dy;
   logic [2:0]         r_colour;

   logic w_tick_tc, w_div_tc, w_shdiv_tc, w_tick, w_consume;
   logic w_pix, w_first_px, w_game_over;
   logic [2:0] w_cell_colour;

   tick_divider #(.N(TICK_CYCLES)) u_tick_cnt (
      .clock(clock), .resetn(resetn), .i_en(enable), .o_tc(w_tick_tc));
   tick_divider #(.N(SHIFT_DIV)) u_tick_div (
      .clock(clock), .resetn(resetn), .i_en(enable && (r_state == ST_UPDATE)), .o_tc(w_div_tc));
   tick_divider #(.N(SPAWN_DIV)) u_shift_div (
      .clock(clock), .resetn(resetn), .i_en(w_div_tc), .o_tc(w_shdiv_tc));

   assign w_pix         = (r_state == ST_PIX);
   assign w_first_px    = (r_dx == '0) && (r_dy == '0);
   assign w_cell_colour = cell_colour(cell_data);
   assign w_tick        = w_tick_tc && !w_game_over;
   assign w_consume     = enable && (r_state == ST_IDLE) && r_pending;

`ifdef FRAME_SEQ_COLLISION_EN
   logic r_game_over;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         r_game_over <= 1'b0;
      else if (enable && w_pix && w_first_px && cell_data &&
               (r_col == player_col) && (r_row == 5'(GRID_H - 3)))
         r_game_over <= 1'b1;
   end

   assign w_game_over = r_game_over;
`else
   logic w_unused;
   assign w_unused    = &{1'b0, player_col};
   assign w_game_over = 1'b0;
`endif

   // A tick landing in the same cycle IDLE consumes the flag re-arms it
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_consume) begin
         r_pending <= w_tick;
      end else if (w_tick) begin
         if (r_pending)
            r_overrun <= 1'b1;
         r_pending <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_do_shift <= 1'b0;
         r_do_spawn <= 1'b0;
         r_col      <= '0;
         r_row      <= '0;
         r_dx       <= '0;
         r_dy       <= '0;
         r_colour   <= '0;
      end else if (enable) begin
         case (r_state)
            ST_IDLE:   if (r_pending) r_state <= ST_UPDATE;
            ST_UPDATE: begin
               r_do_shift <= w_div_tc;
               r_do_spawn <= w_shdiv_tc;
               r_state    <= ST_SPAWN;
            end
            ST_SPAWN:  r_state <= ST_SHIFT;
            ST_SHIFT:  r_state <= ST_ADDR;
            ST_ADDR:   r_state <= ST_PIX;
            ST_PIX: begin
               if (w_first_px)
                  r_colour <= w_cell_colour;
               if (r_dx == SCALE_W'(SCALE - 1)) begin
                  r_dx <= '0;
                  if (r_dy == SCALE_W'(SCALE - 1)) begin
                     r_dy    <= '0;
                     r_state <= ST_ADDR;
                     if (r_row == 5'(GRID_H - 1)) begin
                        r_row <= '0;
                        if (r_col == 4'(GRID_W - 1)) begin
                           r_col   <= '0;
                           r_state <= ST_DONE;
                        end else begin
                           r_col <= r_col + 1'b1;
                        end
                     end else begin
                        r_row <= r_row + 1'b1;
                     end
                  end else begin
                     r_dy <= r_dy + 1'b1;
                  end
               end else begin
                  r_dx <= r_dx + 1'b1;
               end
            end
            ST_DONE:   r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign cell_col    = r_col;
   assign cell_row    = r_row;
   assign busy        = (r_state != ST_IDLE);
   assign plot        = enable && w_pix;
   assign spawn_pulse = enable && (r_state == ST_SPAWN) && r_do_spawn;
   assign shift_pulse = enable && (r_state == ST_SHIFT) && r_do_shift;
   assign frame_done  = enable && (r_state == ST_DONE);
   assign overrun     = r_overrun;
   assign game_over   = w_game_over;
   assign x      = w_pix ? 8'(int'(r_col) * SCALE + int'(r_dx)) : 8'd0;
   assign y      = w_pix ? 7'(int'(r_row) * SCALE + int'(r_dy)) : 7'd0;
   // Cell read data is only valid on the first PIX cycle, so it is held after that
   assign colour = w_pix ? (w_first_px ? w_cell_colour : r_colour) : 3'd0;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer
module tb_frame_sequencer;

   localparam int TICK_A = 5500;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clock) cyc++;

   // DUT A: long tick, pulse ordering, redraw scoreboard, enable, collision
   logic       resetn_a, enable_a, cell_data_a;
   logic [3:0] player_col_a, cell_col_a;
   logic [4:0] cell_row_a;
   logic       spawn_pulse_a, shift_pulse_a, plot_a, busy_a, frame_done_a, overrun_a, game_over_a;
   logic [7:0] x_a;
   logic [6:0] y_a;
   logic [2:0] colour_a;

   // DUT B: 8-cycle tick, reset and overrun
   logic       resetn_b, enable_b;
   logic       cell_data_b = 1'b0;
   logic [3:0] player_col_b = 4'd0;
   logic [3:0] cell_col_b;
   logic [4:0] cell_row_b;
   logic       spawn_pulse_b, shift_pulse_b, plot_b, busy_b, frame_done_b, overrun_b, game_over_b;
   logic [7:0] x_b;
   logic [6:0] y_b;
   logic [2:0] colour_b;

   frame_sequencer #(.TICK_CYCLES(TICK_A), .SHIFT_DIV(2), .SPAWN_DIV(2)) u_a (
      .clock(clock), .resetn(resetn_a), .enable(enable_a),
      .cell_col(cell_col_a), .cell_row(cell_row_a), .cell_data(cell_data_a),
      .player_col(player_col_a), .spawn_pulse(spawn_pulse_a), .shift_pulse(shift_pulse_a),
      .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a), .busy(busy_a),
      .frame_done(frame_done_a), .overrun(overrun_a), .game_over(game_over_a));

   frame_sequencer #(.TICK_CYCLES(8), .SHIFT_DIV(1), .SPAWN_DIV(1)) u_b (
      .clock(clock), .resetn(resetn_b), .enable(enable_b),
      .cell_col(cell_col_b), .cell_row(cell_row_b), .cell_data(cell_data_b),
      .player_col(player_col_b), .spawn_pulse(spawn_pulse_b), .shift_pulse(shift_pulse_b),
      .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b), .busy(busy_b),
      .frame_done(frame_done_b), .overrun(overrun_b), .game_over(game_over_b));

   logic grid [0:15][0:31];
   always @(posedge clock) cell_data_a <= grid[cell_col_a][cell_row_a];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [17:0] exp_q[$];
   int plot_cnt, spawn_cnt, shift_cnt, done_cnt, spawn_cyc, shift_cyc;

   always @(negedge clock) begin
      if (resetn_a) begin
         if (plot_a) begin
            plot_cnt++;
            if (exp_q.size() == 0)
               chk("pixel_unexpected", {14'd0, x_a, y_a, colour_a}, 32'hffff_ffff);
            else
               chk("pixel_xyc", {14'd0, x_a, y_a, colour_a}, {14'd0, exp_q.pop_front()});
         end
         if (spawn_pulse_a) begin spawn_cnt++; spawn_cyc = cyc; end
         if (shift_pulse_a) begin shift_cnt++; shift_cyc = cyc; end
         if (frame_done_a) done_cnt++;
      end
   end

   typedef struct {
      int upd;
      bit spawn;
      bit shift;
   } vec_t;

   vec_t vec [8];

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int busy_seen;
      vec = '{'{1, 1'b0, 1'b0}, '{2, 1'b0, 1'b1}, '{3, 1'b0, 1'b0}, '{4, 1'b1, 1'b1},
              '{5, 1'b0, 1'b0}, '{6, 1'b0, 1'b1}, '{7, 1'b0, 1'b0}, '{8, 1'b1, 1'b1}};
      for (int c = 0; c < 16; c++)
         for (int r = 0; r < 32; r++)
            grid[c][r] = 1'b0;
      grid[2][5]   = 1'b1;
      grid[4][29]  = 1'b1;
      player_col_a = 4'd7;
      resetn_a = 1'b0;
      resetn_b = 1'b0;
      enable_a = 1'b1;
      enable_b = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy_a", busy_a, 0);
      chk("rst_plot_a", plot_a, 0);
      chk("rst_xy_a", {x_a, y_a, colour_a}, 0);
      chk("rst_flags_a", {spawn_pulse_a, shift_pulse_a, frame_done_a, overrun_a, game_over_a}, 0);
      chk("rst_cell_a", {cell_col_a, cell_row_a}, 0);

      // reset mid-PIX on B
      resetn_b = 1'b1;
      k = 0;
      while (!plot_b && k < 40) begin @(posedge clock); #1; k++; end
      chk("b_reached_pix", plot_b, 1);
      #2 resetn_b = 1'b0;
      #1;
      chk("midpix_rst_plot", plot_b, 0);
      chk("midpix_rst_busy", busy_b, 0);
      chk("midpix_rst_xyc", {x_b, y_b, colour_b}, 0);
      chk("midpix_rst_cell", {cell_col_b, cell_row_b}, 0);
      chk("midpix_rst_flags", {spawn_pulse_b, shift_pulse_b, frame_done_b, overrun_b}, 0);
      @(posedge clock);
      #1 resetn_b = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         @(posedge clock); #1;
         if (spawn_pulse_b && e < 10) chk("b_early_spawn", e, 0);
         if (e == 8)  chk("b_busy_before_tick", busy_b, 0);
         if (e == 9)  chk("b_busy_after_tick", busy_b, 1);
         if (e == 23) chk("b_overrun_early", overrun_b, 0);
         if (e == 24) chk("b_overrun_set", overrun_b, 1);
      end
      k = 0;
      while (!frame_done_b && k < 6000) begin @(posedge clock); #1; k++; end
      chk("b_frame_done", frame_done_b, 1);
      @(posedge clock); #1;
      chk("b_idle_after_done", busy_b, 0);
      @(posedge clock); #1;
      chk("b_next_redraw", busy_b, 1);
      chk("b_overrun_sticky", overrun_b, 1);

      // DUT A: nine updates through the scoreboard
      resetn_a = 1'b1;
      for (int u = 0; u < 9; u++) begin
         if (u == 8) player_col_a = 4'd4;
         k = 0;
         while (!busy_a && k < TICK_A + 200) begin @(posedge clock); #1; k++; end
         chk("a_busy_start", busy_a, 1);
         if (!busy_a) break;
         spawn_cnt = 0; shift_cnt = 0; plot_cnt = 0; done_cnt = 0;
         spawn_cyc = 0; shift_cyc = 0;
         for (int c = 0; c < 16; c++)
            for (int r = 0; r < 32; r++)
               for (int dy = 0; dy < 3; dy++)
                  for (int dx = 0; dx < 3; dx++)
                     exp_q.push_back({8'(c * 3 + dx), 7'(r * 3 + dy),
                                      grid[c][r] ? 3'b000 : 3'b001});
         if (u == 2) begin
            repeat (1000) @(posedge clock);
            #1;
            k = 0;
            while (!plot_a && k < 10) begin @(posedge clock); #1; k++; end
            enable_a = 1'b0;
            for (int i = 0; i < 50; i++) begin
               @(posedge clock); #1;
               chk("plot_while_disabled", plot_a, 0);
            end
            enable_a = 1'b1;
         end
         k = 0;
         while (done_cnt == 0 && k < 6000) begin @(posedge clock); #1; k++; end
         @(posedge clock); #1;
         chk("a_frame_done_once", done_cnt, 1);
         chk("a_idle_after_done", busy_a, 0);
         chk("a_plot_count", plot_cnt, 4608);
         chk("a_queue_drained", exp_q.size(), 0);
         exp_q.delete();
         if (u < 8) begin
            chk($sformatf("spawn_upd%0d", vec[u].upd), spawn_cnt, {31'd0, vec[u].spawn});
            chk($sformatf("shift_upd%0d", vec[u].upd), shift_cnt, {31'd0, vec[u].shift});
            if (vec[u].spawn && vec[u].shift)
               chk($sformatf("spawn_lead_upd%0d", vec[u].upd), shift_cyc - spawn_cyc, 1);
         end
      end
      chk("a_no_overrun", overrun_a, 0);
`ifdef FRAME_SEQ_COLLISION_EN
      chk("a_game_over", game_over_a, 1);
      busy_seen = 0;
      for (int i = 0; i < 2 * TICK_A; i++) begin
         @(posedge clock); #1;
         if (busy_a) busy_seen++;
      end
      chk("a_frozen_after_game_over", busy_seen, 0);
      chk("a_no_overrun_after_game_over", overrun_a, 0);
`else
      busy_seen = 0;
      chk("a_game_over_tied", game_over_a, 0);
      chk("a_busy_seen_init", busy_seen, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
